// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared FSM encodings and sizing helper for serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_RUN  = RUN,
      ST_DONE = DONE
   } state_e;

   // One extra bit so the counter can represent WIDTH itself without wrapping.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : Single-bit combinational full adder for the serial datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder/subtractor, LSB first, one bit per clock.
//               Subtraction is enabled by defining SERIAL_ADDER_SUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             SUB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             C
);

   localparam int CW = cnt_width(WIDTH);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-2:0] r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_cy;

   logic             w_sub;
   logic             w_s;
   logic             w_co;
   logic [WIDTH-1:0] w_sum_next;

`ifdef SERIAL_ADDER_SUB_EN
   assign w_sub = SUB;
`else
   // Add-only build: SUB is kept on the interface but forced inactive.
   assign w_sub = SUB & 1'b0;
`endif

   full_adder u_fa (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .cin  (r_cy),
      .s    (w_s),
      .cout (w_co)
   );

   // New sum bit enters at the MSB; the register keeps the upper WIDTH-1 bits.
   assign w_sum_next = {w_s, r_sum};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_cy    <= 1'b0;
         S       <= '0;
         C       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a     <= A;
                  r_b     <= B ^ {WIDTH{w_sub}};
                  r_cy    <= w_sub;
                  r_cnt   <= '0;
                  r_sum   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_sum <= w_sum_next[WIDTH-1:1];
               r_cy  <= w_co;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(WIDTH - 1)) begin
                  S       <= w_sum_next;
                  C       <= w_co;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (r_state == RUN) || (r_state == DONE);
   assign done = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module      : tb_serial_adder
// Description : Directed, table-driven self-checking bench for serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] A = '0;
   logic [7:0] B = '0;
   logic       SUB = 1'b0;
   logic       busy;
   logic       done;
   logic [7:0] S;
   logic       C;

   int checks = 0;
   int errors = 0;

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
      .SUB   (SUB),
      .busy  (busy),
      .done  (done),
      .S     (S),
      .C     (C)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic [7:0] exp_s;
      logic       exp_c;
   } vec_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Launch one operation and follow it to completion, measuring latency and busy time.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                         output int lat, output int busy_cnt, output logic s_moved);
      logic [7:0] s_before;
      @(negedge clk);
      A = a; B = b; SUB = sub; start = 1'b1;
      s_before = S;
      @(negedge clk);
      start = 1'b0;
      A = ~a; B = ~b;
      lat = 1; busy_cnt = 0; s_moved = 1'b0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         if (S !== s_before) s_moved = 1'b1;
         @(negedge clk);
         lat++;
      end
      if (done && busy) busy_cnt++;
   endtask

   vec_t vecs[7];

   initial begin
      int lat;
      int bc;
      logic moved;
      logic saw_done;

      vecs[0] = '{8'h3C, 8'h15, 1'b0, 8'h51, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
`ifdef SERIAL_ADDER_SUB_EN
      vecs[5] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0};
      vecs[6] = '{8'h50, 8'h20, 1'b1, 8'h30, 1'b1};
`else
      vecs[5] = '{8'h10, 8'h20, 1'b1, 8'h30, 1'b0};
      vecs[6] = '{8'h50, 8'h20, 1'b1, 8'h70, 1'b0};
`endif

      repeat (3) @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_S", 64'(S), 64'd0);
      check("reset_C", 64'(C), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat, bc, moved);
         check($sformatf("v%0d_latency", i), 64'(lat), 64'd9);
         check($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'd9);
         check($sformatf("v%0d_S_stable_in_run", i), 64'(moved), 64'd0);
         check($sformatf("v%0d_S", i), 64'(S), 64'(vecs[i].exp_s));
         check($sformatf("v%0d_C", i), 64'(C), 64'(vecs[i].exp_c));
         @(negedge clk);
         check($sformatf("v%0d_done_one_cycle", i), 64'(done), 64'd0);
         check($sformatf("v%0d_idle_after", i), 64'(busy), 64'd0);
      end

      // start held high across a whole operation; operands change mid-run.
      @(negedge clk);
      A = 8'h01; B = 8'h02; SUB = 1'b0; start = 1'b1;
      @(negedge clk);
      A = 8'h05; B = 8'h06;
      lat = 1;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("held_first_latency", 64'(lat), 64'd9);
      check("held_first_S", 64'(S), 64'h03);
      @(negedge clk);
      check("held_idle_gap", 64'(busy), 64'd0);
      @(negedge clk);
      check("held_second_started", 64'(busy), 64'd1);
      moved = 1'b0;
      lat = 1;
      while (!done && lat < 40) begin
         if (S !== 8'h03) moved = 1'b1;
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check("held_first_S_kept", 64'(moved), 64'd0);
      check("held_second_latency", 64'(lat), 64'd9);
      check("held_second_S", 64'(S), 64'h0B);
      check("held_second_C", 64'(C), 64'd0);
      @(negedge clk);
      @(negedge clk);
      check("held_no_third", 64'(busy), 64'd0);

      // Reset in the middle of a run aborts without a done pulse.
      @(negedge clk);
      A = 8'hAA; B = 8'h55; SUB = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      saw_done = 1'b0;
      repeat (3) begin
         if (done) saw_done = 1'b1;
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_S", 64'(S), 64'd0);
      check("abort_C", 64'(C), 64'd0);
      repeat (12) begin
         if (done) saw_done = 1'b1;
         @(negedge clk);
      end
      check("abort_no_done", 64'(saw_done), 64'd0);

      run_op(8'hAA, 8'h55, 1'b0, lat, bc, moved);
      check("fresh_latency", 64'(lat), 64'd9);
      check("fresh_S", 64'(S), 64'hFF);
      check("fresh_C", 64'(C), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand bit width (legal range 2..64).
REQ-002 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  is the reset: synchronous and active-low.
REQ-004 Port start  input  1  requests an operation; it is sampled only in IDLE.
REQ-005 Port A  input  WIDTH  is operand A, captured on an accepted start.
REQ-006 Port B  input  WIDTH  is operand B, captured on an accepted start.
REQ-007 Port SUB  input  1  selects the mode: 0 = add, 1 = subtract (A-B). It is captured on an accepted start.
REQ-008 Port busy  output  1  SHALL be high while an operation is in progress.
REQ-009 Port done  output  1  SHALL be a single-cycle completion pulse.
REQ-010 Port S  output  WIDTH  is the registered sum/difference.
REQ-011 Port C  output  1  is the registered carry-out of the MSB.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 IDLE->RUN SHALL occur on start=1. A, B and SUB are loaded into shift registers, the bit counter is cleared to 0, and the carry flop is loaded with the carry-in.
REQ-014 In RUN, each cycle SHALL process one bit, LSB first:
  - the full adder combines A[0], B'[0] and the carry flop;
  - the sum bit is shifted into the MSB of the result register, which shifts right;
  - the carry flop takes the bit's carry-out;
  - the counter increments.
REQ-015 RUN->DONE SHALL occur after exactly WIDTH bit-cycles. On that transition S receives the completed result and C receives the final carry.
REQ-016 DONE SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-017 Latency from the start edge to the done=1 cycle SHALL be WIDTH+1 cycles. busy SHALL be high in RUN and DONE.
REQ-018 start while busy=1 SHALL be ignored: no restart, no capture, no error.
REQ-019 start asserted in the same cycle that DONE returns to IDLE SHALL be ignored. A new start is accepted only from IDLE on the following cycle.
REQ-020 S and C SHALL hold their last result until the next completion. They SHALL NOT change during RUN.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH. C is the true carry-out; in subtract mode C=1 means no borrow (A>=B unsigned).
REQ-022 The counter SHALL be $clog2(WIDTH)+1 bits wide so that WIDTH is reachable without wrap.

Reset
REQ-023 On rst_n=0 at a clock edge, the block SHALL enter IDLE with busy=0, done=0, S=0, C=0, counter=0, carry flop=0, and shift registers cleared.
REQ-024 Reset asserted mid-RUN SHALL abort the operation, produce no done pulse, and leave S/C at zero.

Configuration
REQ-025 Macro SERIAL_ADDER_SUB_EN defined: SUB is honoured. SUB=1 inverts B on load and sets carry-in=1.
REQ-026 Macro SERIAL_ADDER_SUB_EN undefined: the SUB port SHALL still exist but be ignored. The block is add-only, with carry-in=0 and B uninverted.

Structure
REQ-027 Package serial_adder_pkg SHALL hold:
  - the state enum (IDLE, RUN, DONE);
  - the localparam function for counter width.
REQ-028 Sub-module full_adder (inputs a, b, cin; outputs s, cout) SHALL be instantiated once for the per-bit datapath. It is purely combinational.

Verification (WIDTH=8)
REQ-029 Add: A=0x3C, B=0x15, SUB=0, start pulse -> done on cycle 9 after start; S=0x51, C=0.
REQ-030 Overflow: A=0xFF, B=0x01, SUB=0 -> S=0x00, C=1. busy is high for exactly 9 cycles.
REQ-031 Subtract (SUB_EN defined): A=0x10, B=0x20, SUB=1 -> S=0xF0, C=0. Rerun with SUB_EN undefined -> S=0x30, C=0.
REQ-032 start held high throughout the first operation -> second operation begins only after the IDLE cycle. The first result (A=0x01, B=0x02 -> S=0x03) is held during the second RUN.
REQ-033 rst_n=0 for one cycle at bit-cycle 4 of A=0xAA+B=0x55 -> no done; S=0, C=0, busy=0 next cycle. A fresh start then completes normally with S=0xFF, C=0.
